// File: rtl/fetch_unit_pkg.sv
// Shared fetch front-end types: FSM state encoding and the canonical NOP.
package fetch_pack;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SQUASH = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/fetch_unit_imem_bank.sv
// Instruction memory: one synchronous write port, one combinational read port.
module imem_bank
  import fetch_pack::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          CLK,
  input  logic                          WE,
  input  logic [$clog2(IMEM_DEPTH)-1:0] WADDR,
  input  logic [XLEN-1:0]               WDATA,
  input  logic [$clog2(IMEM_DEPTH):0]   RADDR,
  output logic [XLEN-1:0]               RDATA
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge CLK) begin
    if (WE && (32'(WADDR) < 32'(IMEM_DEPTH)))
      mem[WADDR] <= WDATA;
  end

  // The read index is one bit wider than the array; anything past the end reads as NOP.
  assign RDATA = (32'(RADDR) < 32'(IMEM_DEPTH)) ? mem[RADDR[AW-1:0]] : XLEN'(NOP_INST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: loadable imem, PC, redirect squash and end-of-program drain.
module fetch_unit
  import fetch_pack::*;
#(
  parameter int XLEN           = 32,
  parameter int IMEM_DEPTH     = 64,
  parameter int PC_W           = $clog2(IMEM_DEPTH),
  parameter int BRANCH_PENALTY = 2,
  parameter int DRAIN_CYCLES   = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LOAD_EN,
  input  logic [PC_W-1:0] LOAD_ADDR,
  input  logic [XLEN-1:0] LOAD_DATA,
  input  logic            START,
  input  logic [PC_W-1:0] LAST_PC,
  input  logic            STALL,
  input  logic            REDIRECT,
  input  logic [PC_W-1:0] REDIRECT_PC,
  output logic [XLEN-1:0] INST,
  output logic [PC_W-1:0] INST_PC,
  output logic            INST_VALID,
  output logic            BUSY,
  output logic            COMPLETED,
  output logic [31:0]     FETCH_COUNT
);

  localparam int CNT_MAX = (BRANCH_PENALTY > DRAIN_CYCLES) ? BRANCH_PENALTY : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [PC_W-1:0] MAX_IDX = PC_W'(IMEM_DEPTH - 1);

  fetch_state_t     state;
  logic [PC_W:0]    pc;
  logic [PC_W-1:0]  last_pc;
  logic [CNT_W-1:0] sq_cnt;
  logic [CNT_W-1:0] dr_cnt;
  logic [XLEN-1:0]  rd_data;
  logic             idle_like;
  logic             load_we;
  logic             fetch_ok;
  logic [PC_W-1:0]  last_clamp;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign load_we    = LOAD_EN && idle_like && !RST;
  assign fetch_ok   = (pc <= {1'b0, last_pc});
  assign last_clamp = (32'(LAST_PC) > 32'(IMEM_DEPTH - 1)) ? MAX_IDX : LAST_PC;
  assign BUSY       = (state == RUN) || (state == SQUASH) || (state == DRAIN);

  imem_bank #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH)) u_imem (
    .CLK   (CLK),
    .WE    (load_we),
    .WADDR (LOAD_ADDR),
    .WDATA (LOAD_DATA),
    .RADDR (pc),
    .RDATA (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      pc          <= '0;
      last_pc     <= '0;
      sq_cnt      <= '0;
      dr_cnt      <= '0;
      INST        <= XLEN'(NOP_INST);
      INST_PC     <= '0;
      INST_VALID  <= 1'b0;
      COMPLETED   <= 1'b0;
      FETCH_COUNT <= '0;
    end else if (REDIRECT && BUSY) begin
      // Redirect beats STALL and restarts any squash or drain already in progress.
      INST       <= XLEN'(NOP_INST);
      INST_VALID <= 1'b0;
      pc         <= {1'b0, REDIRECT_PC};
      sq_cnt     <= CNT_W'(BRANCH_PENALTY - 1);
      state      <= (BRANCH_PENALTY == 1) ? RUN : SQUASH;
    end else begin
      case (state)
        IDLE, DONE: begin
          INST       <= XLEN'(NOP_INST);
          INST_VALID <= 1'b0;
          if (START) begin
            pc          <= '0;
            last_pc     <= last_clamp;
            FETCH_COUNT <= '0;
            COMPLETED   <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (!STALL) begin
            if (fetch_ok) begin
              INST       <= rd_data;
              INST_PC    <= pc[PC_W-1:0];
              INST_VALID <= 1'b1;
              pc         <= pc + (PC_W+1)'(1);
              if (FETCH_COUNT != '1) FETCH_COUNT <= FETCH_COUNT + 32'd1;
            end else begin
              INST       <= XLEN'(NOP_INST);
              INST_VALID <= 1'b0;
              dr_cnt     <= CNT_W'(DRAIN_CYCLES);
              state      <= DRAIN;
            end
          end
        end
        SQUASH: begin
          INST       <= XLEN'(NOP_INST);
          INST_VALID <= 1'b0;
          // Leaving on the edge the count reaches zero gives exactly BRANCH_PENALTY bubbles.
          if (sq_cnt <= CNT_W'(1)) begin
            sq_cnt <= '0;
            state  <= RUN;
          end else begin
            sq_cnt <= sq_cnt - CNT_W'(1);
          end
        end
        DRAIN: begin
          INST       <= XLEN'(NOP_INST);
          INST_VALID <= 1'b0;
          if (dr_cnt <= CNT_W'(1)) begin
            dr_cnt    <= '0;
            COMPLETED <= 1'b1;
            state     <= DONE;
          end else begin
            dr_cnt <= dr_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a per-cycle expected-output scoreboard.
module tb_fetch_unit;
  import fetch_pack::*;

  localparam int W = 6;

  logic          CLK = 1'b0;
  logic          RST, LOAD_EN, START, STALL, REDIRECT;
  logic [W-1:0]  LOAD_ADDR, LAST_PC, REDIRECT_PC;
  logic [31:0]   LOAD_DATA;
  logic [31:0]   INST;
  logic [W-1:0]  INST_PC;
  logic          INST_VALID, BUSY, COMPLETED;
  logic [31:0]   FETCH_COUNT;

  fetch_unit #(.XLEN(32), .IMEM_DEPTH(64), .BRANCH_PENALTY(2), .DRAIN_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .START(START), .LAST_PC(LAST_PC), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID),
    .BUSY(BUSY), .COMPLETED(COMPLETED), .FETCH_COUNT(FETCH_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [W-1:0] rpc;
    logic        ld;
    logic        ev;
    logic [W-1:0] epc;
    logic        ecomp;
    int unsigned efc;
  } vec_t;

  vec_t        vq[$];
  vec_t        sb[$];
  logic [31:0] img [64];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(logic st, logic rd, logic [W-1:0] rp, logic ev,
                              logic [W-1:0] ep, logic ec, int unsigned fc, logic ld = 1'b0);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rp; v.ld = ld;
    v.ev = ev; v.epc = ep; v.ecomp = ec; v.efc = fc;
    vq.push_back(v);
  endfunction

  function automatic void add_run(int first, int last, int unsigned fc0);
    for (int p = first; p <= last; p++)
      add(1'b0, 1'b0, '0, 1'b1, W'(p), 1'b0, fc0 + 32'(p - first + 1));
  endfunction

  // Two drain bubbles, then COMPLETED, then one more cycle to show it holds in DONE.
  function automatic void add_drain(int unsigned fc);
    add(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, fc);
    add(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, fc);
    add(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, fc);
    add(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, fc);
  endfunction

  task automatic apply(string tag);
    vec_t e;
    for (int i = 0; i < vq.size(); i++) begin
      STALL       = vq[i].stall;
      REDIRECT    = vq[i].redir;
      REDIRECT_PC = vq[i].rpc;
      LOAD_EN     = vq[i].ld;
      LOAD_ADDR   = '0;
      LOAD_DATA   = 32'hFFFF_FFFF;
      sb.push_back(vq[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      chk($sformatf("%s[%0d] valid", tag, i), 64'(INST_VALID), 64'(e.ev));
      if (e.ev) chk($sformatf("%s[%0d] inst_pc", tag, i), 64'(INST_PC), 64'(e.epc));
      chk($sformatf("%s[%0d] inst", tag, i), 64'(INST), 64'(e.ev ? img[e.epc] : NOP_INST));
      chk($sformatf("%s[%0d] completed", tag, i), 64'(COMPLETED), 64'(e.ecomp));
      chk($sformatf("%s[%0d] busy", tag, i), 64'(BUSY), 64'(!e.ecomp));
      chk($sformatf("%s[%0d] fetch_count", tag, i), 64'(FETCH_COUNT), 64'(e.efc));
    end
    vq.delete();
    STALL = 1'b0; REDIRECT = 1'b0; LOAD_EN = 1'b0;
  endtask

  task automatic start(string tag, logic [W-1:0] lp, logic ld, logic [31:0] d);
    START = 1'b1; LAST_PC = lp; LOAD_EN = ld; LOAD_ADDR = '0; LOAD_DATA = d;
    @(posedge CLK); #1;
    START = 1'b0; LOAD_EN = 1'b0;
    if (ld) img[0] = d;
    chk({tag, " start valid"}, 64'(INST_VALID), 64'd0);
    chk({tag, " start busy"}, 64'(BUSY), 64'd1);
    chk({tag, " start completed"}, 64'(COMPLETED), 64'd0);
    chk({tag, " start fetch_count"}, 64'(FETCH_COUNT), 64'd0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " inst"}, 64'(INST), 64'(NOP_INST));
    chk({tag, " inst_pc"}, 64'(INST_PC), 64'd0);
    chk({tag, " valid"}, 64'(INST_VALID), 64'd0);
    chk({tag, " completed"}, 64'(COMPLETED), 64'd0);
    chk({tag, " fetch_count"}, 64'(FETCH_COUNT), 64'd0);
    chk({tag, " busy"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    RST = 1'b1; LOAD_EN = 1'b0; START = 1'b0; STALL = 1'b0; REDIRECT = 1'b0;
    LOAD_ADDR = '0; LAST_PC = '0; REDIRECT_PC = '0; LOAD_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset("reset");
    RST = 1'b0;

    for (int i = 0; i < 64; i++) begin
      img[i] = 32'hC0DE_0000 + 32'(i);
      LOAD_EN = 1'b1; LOAD_ADDR = W'(i); LOAD_DATA = img[i];
      @(posedge CLK); #1;
    end
    // A write under reset must be dropped; word 5 is fetched later in t4.
    RST = 1'b1; LOAD_ADDR = W'(5); LOAD_DATA = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    RST = 1'b0; LOAD_EN = 1'b0;
    chk_reset("reset_ld");

    // t1: straight-line run of four words
    start("t1", W'(3), 1'b0, '0);
    add_run(0, 3, 0); add_drain(4);
    apply("t1");

    // t2: stall holds the instruction at index 1
    start("t2", W'(3), 1'b0, '0);
    add_run(0, 1, 0);
    repeat (3) add(1'b1, 1'b0, '0, 1'b1, W'(1), 1'b0, 2);
    add_run(2, 3, 2); add_drain(4);
    apply("t2");

    // t3: redirect to 8 while index 3 is on the output
    start("t3", W'(10), 1'b0, '0);
    add_run(0, 3, 0);
    add(1'b0, 1'b1, W'(8), 1'b0, '0, 1'b0, 4);
    add(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 4);
    add_run(8, 10, 4); add_drain(7);
    apply("t3");

    // t4: redirect beats stall, then a second redirect restarts the penalty
    start("t4", W'(10), 1'b0, '0);
    add_run(0, 0, 0);
    add(1'b1, 1'b1, W'(8), 1'b0, '0, 1'b0, 1);
    add(1'b1, 1'b1, W'(5), 1'b0, '0, 1'b0, 1);
    add(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1);
    add_run(5, 10, 1); add_drain(7);
    apply("t4");

    // t5: load+start on one edge, then redirect on the first drain cycle
    start("t5", W'(1), 1'b1, 32'h0BAD_F00D);
    add_run(0, 1, 0);
    add(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 2);
    add(1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 2);
    add(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 2);
    add_run(0, 1, 2); add_drain(4);
    apply("t5");

    img[0] = 32'hC0DE_0000;
    LOAD_EN = 1'b1; LOAD_ADDR = '0; LOAD_DATA = img[0];
    @(posedge CLK); #1;
    LOAD_EN = 1'b0;

    // t6: load attempt during RUN, reset mid-run, then a full-depth run
    start("t6a", W'(63), 1'b0, '0);
    add_run(0, 2, 0);
    add(1'b0, 1'b0, '0, 1'b1, W'(3), 1'b0, 4, 1'b1);
    add_run(4, 4, 4);
    apply("t6a");
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_reset("t6_rst");
    start("t6b", W'(63), 1'b0, '0);
    add_run(0, 63, 0); add_drain(64);
    apply("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the in-order RISC-V core. It holds a loadable instruction memory and the PC, and presents one instruction per cycle to the decoder through a valid/stall handshake. It takes branch redirects from the execute stage with a configurable squash penalty, drains the pipeline after the last instruction, and then raises COMPLETED. It replaces the hard-coded program array, fixed 2-cycle branch stall and PC-compare completion inside the cpu module.

Parameters:
XLEN, 32, instruction width in bits
IMEM_DEPTH, 64, instruction memory depth in words (any value >= 2)
PC_W, $clog2(IMEM_DEPTH), word-index width (derived; do not override)
BRANCH_PENALTY, 2, bubble cycles after a redirect (>= 1)
DRAIN_CYCLES, 2, cycles after end of program before COMPLETED (>= 1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
LOAD_EN  in  1  imem write strobe; honoured only in IDLE or DONE
LOAD_ADDR  in  PC_W  imem write word index
LOAD_DATA  in  XLEN  imem write data
START  in  1  begin a run at word 0; honoured only in IDLE or DONE
LAST_PC  in  PC_W  index of the final program word; sampled on the START edge
STALL  in  1  decoder not ready; hold the current instruction
REDIRECT  in  1  taken branch or jump resolved in execute
REDIRECT_PC  in  PC_W  word index of the redirect target
INST  out  XLEN  instruction to the decoder
INST_PC  out  PC_W  word index of INST
INST_VALID  out  1  INST is a real program instruction
BUSY  out  1  state is RUN, SQUASH or DRAIN
COMPLETED  out  1  program finished and pipeline drained
FETCH_COUNT  out  32  valid instructions issued in this run

Behaviour:
- Reset values: state=IDLE, pc=0, INST=NOP (32'h00000013), INST_PC=0, INST_VALID=0, COMPLETED=0, FETCH_COUNT=0.
- RST has priority over every other input, including LOAD_EN. Imem contents are not reset.
- A reset mid-run returns to IDLE on that edge; memory is retained.
- The internal pc is PC_W+1 bits, so pc=LAST_PC+1 never wraps.
- A LAST_PC value >= IMEM_DEPTH is clamped to IMEM_DEPTH-1.
- Imem has a synchronous write and a combinational read. All outputs are registered.
- A bubble means INST=NOP and INST_VALID=0.
- IDLE:
  - Outputs show a bubble.
  - LOAD_EN writes the memory.
  - START sets pc=0, latches LAST_PC, clears FETCH_COUNT and COMPLETED, and moves to RUN.
  - No fetch happens on the START edge. If LOAD_EN and START arrive on the same edge, the write is performed and is visible to the first fetch.
- RUN, on an edge with STALL=0 and pc<=LAST_PC:
  - INST<=imem[pc], INST_PC<=pc, INST_VALID<=1, pc<=pc+1.
  - FETCH_COUNT increments, saturating at 2^32-1.
- RUN, on an edge with STALL=1: INST, INST_PC, INST_VALID, pc and FETCH_COUNT all hold.
- RUN, on an edge with STALL=0 and pc>LAST_PC: output a bubble, load the drain counter with DRAIN_CYCLES, and move to DRAIN.
- REDIRECT, in RUN, SQUASH or DRAIN; it overrides STALL:
  - Output a bubble, set pc<=REDIRECT_PC, load the squash counter with BRANCH_PENALTY-1.
  - Move to SQUASH, or straight to RUN if BRANCH_PENALTY==1.
  - Exactly BRANCH_PENALTY bubble cycles are seen before imem[REDIRECT_PC] appears valid.
- SQUASH:
  - Outputs stay a bubble; the counter decrements every edge regardless of STALL.
  - At 0, move to RUN, which fetches on the following edge.
  - A new REDIRECT during SQUASH restarts the penalty; the latest target wins.
- DRAIN:
  - Outputs stay a bubble; the counter decrements every edge.
  - On the edge where the counter is 1, move to DONE and set COMPLETED<=1.
  - A REDIRECT during DRAIN cancels the drain and follows the SQUASH rules.
- A redirect target > LAST_PC: after the squash, RUN enters DRAIN on its first edge.
- DONE: COMPLETED holds 1 and outputs show a bubble. LOAD_EN is allowed. START behaves as in IDLE.
- The edge that enters DONE is DRAIN_CYCLES edges after the edge that entered DRAIN.
- BUSY is decoded combinationally from the registered state.

Decomposition:
- fetch_pack, alongside def_pack, holds:
  - fetch_state_t enum {IDLE, RUN, SQUASH, DRAIN, DONE}
  - NOP_INST = 32'h00000013
- One sub-module, imem_bank (parameters XLEN and IMEM_DEPTH):
  - one synchronous write port and one combinational read port
  - a read index >= IMEM_DEPTH returns NOP_INST
- fetch_unit owns the FSM, pc, the counters and the output registers.

Test Plan:
- Load 4 words at 0..3, LAST_PC=3, START at edge S, no stall -> INST_PC=0,1,2,3 valid on edges S+1..S+4; bubble at S+5; COMPLETED=1 at S+7; FETCH_COUNT=4; BUSY low afterwards.
- STALL=1 for 3 cycles while INST_PC=1 -> INST stays imem[1] and FETCH_COUNT=2 throughout; INST_PC=2 valid on the first edge after STALL drops.
- REDIRECT with REDIRECT_PC=8 while INST_PC=3 (LAST_PC=10, BRANCH_PENALTY=2) -> exactly 2 bubble cycles, then INST_PC=8 valid; indices 4..7 never valid.
- REDIRECT and STALL high on the same edge -> redirect taken; second REDIRECT to 5 during SQUASH -> 2 fresh bubbles, then INST_PC=5.
- REDIRECT to 0 on the first DRAIN cycle -> COMPLETED stays 0; word 0 re-fetched after the penalty; run later completes normally.
- RST mid-RUN, then START with LAST_PC=63, IMEM_DEPTH=64 -> original data reappears at INST_PC=0; pc does not wrap; COMPLETED rises; FETCH_COUNT=64; LOAD_EN during RUN leaves memory unchanged.
